// File: rtl/ps2_pkg.sv
// Shared constants, frame state encoding and a parity helper for the PS/2 receiver.
package ps2_pkg;

   localparam logic [7:0] PS2_BREAK = 8'hF0;
   localparam logic [7:0] PS2_EXT   = 8'hE0;
   localparam logic [7:0] PS2_BKSP  = 8'h66;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } frame_state_t;

   // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
      return ^{d, p};
   endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, frame FSM and
// inactivity timeout. Output handshake: byte_rdy is a one-cycle valid strobe
// with no ready (the consumer must take rx_byte in that cycle); rx_byte is
// meaningful only while byte_rdy is high. frame_err is a one-cycle strobe.
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int TIMEOUT      = 50000,
   parameter bit CHECK_PARITY = 1'b1
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         ps2clk,
   input  logic         ps2data,
   output logic         byte_rdy,
   output logic [7:0]   rx_byte,
   output logic         frame_err,
   output frame_state_t state
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

   logic          clk_s1, clk_s2, clk_s3;
   logic          dat_s1, dat_s2, dat_q;
   logic          fall;
   frame_state_t  state_n;
   logic [2:0]    bit_idx, bit_idx_n;
   logic [7:0]    sr, sr_n;
   logic          par, par_n;
   logic [TW-1:0] to_cnt;
   logic          timeout;

   // Synchronise both pins; data is delayed one extra flop so it lines up with fall.
   always_ff @(posedge CLK) begin
      if (RST) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         clk_s3 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
         dat_q  <= 1'b1;
         fall   <= 1'b0;
      end else begin
         clk_s1 <= ps2clk;
         clk_s2 <= clk_s1;
         clk_s3 <= clk_s2;
         dat_s1 <= ps2data;
         dat_s2 <= dat_s1;
         dat_q  <= dat_s2;
         fall   <= clk_s3 & ~clk_s2;
      end
   end

   // A fall in the same cycle suppresses the timeout so a late edge still counts.
   assign timeout = (state != IDLE) && !fall && (to_cnt == TMAX);

   // Inactivity counter: cleared by every edge, runs only inside a frame.
   always_ff @(posedge CLK) begin
      if (RST) begin
         to_cnt <= '0;
      end else if (fall || (state == IDLE) || timeout) begin
         to_cnt <= '0;
      end else begin
         to_cnt <= to_cnt + TW'(1);
      end
   end

   // Frame FSM state and shift registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         bit_idx <= 3'd0;
         sr      <= 8'h00;
         par     <= 1'b0;
      end else begin
         state   <= state_n;
         bit_idx <= bit_idx_n;
         sr      <= sr_n;
         par     <= par_n;
      end
   end

   // Frame FSM next state, byte strobe and error strobe.
   always_comb begin
      state_n   = state;
      bit_idx_n = bit_idx;
      sr_n      = sr;
      par_n     = par;
      byte_rdy  = 1'b0;
      frame_err = 1'b0;
      if (timeout) begin
         state_n   = IDLE;
         frame_err = 1'b1;
      end else if (fall) begin
         case (state)
            IDLE: begin
               // A high data line on an edge is not a start bit; ignore it.
               if (!dat_q) begin
                  state_n   = DATA;
                  bit_idx_n = 3'd0;
               end
            end
            DATA: begin
               sr_n[bit_idx] = dat_q;
               if (bit_idx == 3'd7) begin
                  state_n = PARITY;
               end else begin
                  bit_idx_n = bit_idx + 3'd1;
               end
            end
            PARITY: begin
               par_n   = dat_q;
               state_n = STOP;
            end
            STOP: begin
               if (dat_q && (!CHECK_PARITY || odd_parity_ok(sr, par))) begin
                  byte_rdy = 1'b1;
               end else begin
                  frame_err = 1'b1;
               end
               state_n = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   assign rx_byte = sr;

endmodule

// File: rtl/ps2_key_buffer.sv
// PS/2 keyboard receiver with make/break/extended decoding and a shifting
// history of make codes (entry 0 newest) with backspace delete.
// Output handshake: key_valid is a one-cycle valid with no ready; key_code and
// key_ext qualify it in that cycle, and keys/count already show the update.
module ps2_key_buffer
   import ps2_pkg::*;
#(
   parameter int         DEPTH        = 8,
   parameter int         TIMEOUT      = 50000,
   parameter logic [7:0] BKSP_CODE    = PS2_BKSP,
   parameter bit         CHECK_PARITY = 1'b1
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         ps2clk,
   input  logic                         ps2data,
   output logic [8*DEPTH-1:0]           keys,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         key_valid,
   output logic [7:0]                   key_code,
   output logic                         key_ext,
   output logic                         frame_err,
   output frame_state_t                 rx_state
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic       byte_rdy;
   logic [7:0] rx_byte;
   logic       rx_err;
   logic       ext, brk;
   logic       is_make;
   logic       buf_push, buf_pop;
   logic [7:0] mem [DEPTH];

   ps2_rx_frame #(
      .TIMEOUT      (TIMEOUT),
      .CHECK_PARITY (CHECK_PARITY)
   ) u_rx (
      .CLK       (CLK),
      .RST       (RST),
      .ps2clk    (ps2clk),
      .ps2data   (ps2data),
      .byte_rdy  (byte_rdy),
      .rx_byte   (rx_byte),
      .frame_err (rx_err),
      .state     (rx_state)
   );

   // Classify the received byte and decide how the history changes.
   always_comb begin
      is_make  = 1'b0;
      buf_push = 1'b0;
      buf_pop  = 1'b0;
      if (byte_rdy && (rx_byte != PS2_EXT) && (rx_byte != PS2_BREAK) && !brk) begin
         is_make = 1'b1;
         if (!ext) begin
            if (rx_byte == BKSP_CODE) begin
               buf_pop = (count != '0);
            end else begin
               buf_push = 1'b1;
            end
         end
      end
   end

   // Prefix flags, key event outputs and error pulse.
   always_ff @(posedge CLK) begin
      if (RST) begin
         ext       <= 1'b0;
         brk       <= 1'b0;
         key_valid <= 1'b0;
         key_code  <= 8'h00;
         key_ext   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         frame_err <= rx_err;
         if (byte_rdy) begin
            if (rx_byte == PS2_EXT) begin
               ext <= 1'b1;
            end else if (rx_byte == PS2_BREAK) begin
               brk <= 1'b1;
            end else if (brk) begin
               brk <= 1'b0;
               ext <= 1'b0;
            end else begin
               key_valid <= 1'b1;
               key_code  <= rx_byte;
               key_ext   <= ext;
               ext       <= 1'b0;
            end
         end
      end
   end

   // History shift register: push shifts toward the oldest slot, pop shifts back.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
         count <= '0;
      end else if (buf_push) begin
         mem[0] <= rx_byte;
         for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
         if (count != DEPTH_C) count <= count + CW'(1);
      end else if (buf_pop) begin
         for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
         mem[DEPTH-1] <= 8'h00;
         count <= count - CW'(1);
      end
   end

   // Flatten the history onto the keys bus, entry i in bits [8i+7:8i].
   always_comb begin
      keys = '0;
      for (int i = 0; i < DEPTH; i++) keys[8*i +: 8] = mem[i];
   end

   // is_make is kept as a named decode term for probing alongside key_valid.
   logic unused_ok;
   assign unused_ok = is_make;

endmodule

// File: tb/tb_ps2_key_buffer.sv
// Bench for ps2_key_buffer: bit-level PS/2 driver, queue-based key-history
// reference model, and a monitor that checks every key_valid/frame_err pulse.
module tb_ps2_key_buffer;
   import ps2_pkg::*;

   localparam int DEPTH   = 8;
   localparam int TIMEOUT = 100;
   localparam logic [1:0] K_KEY = 2'b10;
   localparam logic [1:0] K_ERR = 2'b01;

   typedef struct packed {
      logic [1:0]  kind;
      logic        ext;
      logic [7:0]  code;
      logic [3:0]  cnt;
      logic [63:0] keys;
   } ev_t;
   localparam int EW = $bits(ev_t);

   logic               CLK = 1'b0;
   logic               RST = 1'b1;
   logic               ps2clk = 1'b1;
   logic               ps2data = 1'b1;
   logic [8*DEPTH-1:0] keys;
   logic [3:0]         count;
   logic               key_valid;
   logic [7:0]         key_code;
   logic               key_ext;
   logic               frame_err;
   frame_state_t       rx_state;

   logic [EW-1:0] exp_q[$];
   logic [7:0]    hist[$];
   logic          m_ext = 1'b0;
   logic          m_brk = 1'b0;
   int            total = 0;
   int            bad   = 0;

   ps2_key_buffer #(
      .DEPTH        (DEPTH),
      .TIMEOUT      (TIMEOUT),
      .BKSP_CODE    (8'h66),
      .CHECK_PARITY (1'b1)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .ps2clk    (ps2clk),
      .ps2data   (ps2data),
      .keys      (keys),
      .count     (count),
      .key_valid (key_valid),
      .key_code  (key_code),
      .key_ext   (key_ext),
      .frame_err (frame_err),
      .rx_state  (rx_state)
   );

   // clock / watchdog
   always #5 CLK = ~CLK;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [63:0] model_keys();
      logic [63:0] k = '0;
      for (int i = 0; i < hist.size(); i++) k[8*i +: 8] = hist[i];
      return k;
   endfunction

   task automatic model_reset();
      hist.delete();
      m_ext = 1'b0;
      m_brk = 1'b0;
   endtask

   task automatic model_frame(input logic [7:0] code, input bit is_bad);
      ev_t e = '0;
      if (is_bad) begin
         e.kind = K_ERR;
         exp_q.push_back(EW'(e));
      end else if (code == 8'hE0) begin
         m_ext = 1'b1;
      end else if (code == 8'hF0) begin
         m_brk = 1'b1;
      end else if (m_brk) begin
         m_brk = 1'b0;
         m_ext = 1'b0;
      end else begin
         e.kind = K_KEY;
         e.ext  = m_ext;
         e.code = code;
         if (!m_ext) begin
            if (code == 8'h66) begin
               if (hist.size() > 0) void'(hist.pop_front());
            end else begin
               hist.push_front(code);
               if (hist.size() > DEPTH) void'(hist.pop_back());
            end
         end
         m_ext  = 1'b0;
         e.cnt  = 4'(hist.size());
         e.keys = model_keys();
         exp_q.push_back(EW'(e));
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic ps2_bit(input logic b);
      @(negedge CLK) ps2data = b;
      repeat (4) @(negedge CLK);
      ps2clk = 1'b0;
      repeat (8) @(negedge CLK);
      ps2clk = 1'b1;
      repeat (4) @(negedge CLK);
   endtask

   task automatic send_frame(input logic [7:0] code, input bit flip_par, input bit bad_stop);
      model_frame(code, flip_par || bad_stop);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(code[i]);
      ps2_bit((~^code) ^ flip_par);
      ps2_bit(!bad_stop);
      ps2data = 1'b1;
      repeat (10) @(negedge CLK);
   endtask

   task automatic send_good(input logic [7:0] code);
      send_frame(code, 1'b0, 1'b0);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 1000) begin
         @(negedge CLK);
         n++;
      end
      chk("drain_pending", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   task automatic do_reset();
      @(negedge CLK) RST = 1'b1;
      ps2clk  = 1'b1;
      ps2data = 1'b1;
      repeat (4) @(negedge CLK);
      RST = 1'b0;
      model_reset();
      repeat (4) @(negedge CLK);
   endtask

   task automatic chk_state(input string name);
      chk({name, "_count"}, 64'(count), 64'(hist.size()));
      chk({name, "_keys"}, keys, model_keys());
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge CLK) begin
      if (!RST && (key_valid || frame_err)) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: key_valid=%b frame_err=%b code=%h", key_valid, frame_err, key_code);
         end else begin
            ev_t e;
            e = ev_t'(exp_q.pop_front());
            chk("event_kind", 64'({key_valid, frame_err}), 64'(e.kind));
            if (e.kind == K_KEY) begin
               chk("key_code", 64'(key_code), 64'(e.code));
               chk("key_ext", 64'(key_ext), 64'(e.ext));
               chk("event_count", 64'(count), 64'(e.cnt));
               chk("event_keys", keys, e.keys);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      RST = 1'b1;
      repeat (5) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      chk("rst_keys", keys, 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_pulses", 64'({key_valid, frame_err, key_ext}), 64'd0);
      chk("rst_code", 64'(key_code), 64'd0);
      chk("rst_state", 64'(rx_state), 64'(IDLE));

      // A, B, C
      send_good(8'h1C); send_good(8'h32); send_good(8'h21);
      drain();
      chk("abc_count", 64'(count), 64'd3);
      chk("abc_keys", 64'(keys[23:0]), 64'h1C3221);

      // make, break, release
      do_reset();
      send_good(8'h1C); send_good(8'hF0); send_good(8'h1C);
      drain();
      chk_state("release");

      // overflow then backspace
      do_reset();
      for (int i = 1; i <= 9; i++) send_good(8'(i));
      drain();
      chk("ovf_count", 64'(count), 64'd8);
      chk("ovf_entry0", 64'(keys[7:0]), 64'h09);
      chk("ovf_entry7", 64'(keys[63:56]), 64'h02);
      send_good(8'h66);
      drain();
      chk("bksp_entry0", 64'(keys[7:0]), 64'h08);
      chk("bksp_entry7", 64'(keys[63:56]), 64'h00);
      chk("bksp_count", 64'(count), 64'd7);

      // backspace on empty, then extended make
      do_reset();
      send_good(8'h66);
      send_good(8'hE0); send_good(8'h75);
      drain();
      chk_state("empty_ext");

      // parity and stop errors
      send_frame(8'h1C, 1'b1, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b1);
      drain();
      chk_state("bad_frames");

      // timeout on a partial frame
      model_frame(8'h00, 1'b1);
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(1'(i & 1));
      ps2data = 1'b1;
      repeat (TIMEOUT + 50) @(negedge CLK);
      chk("timeout_idle", 64'(rx_state), 64'(IDLE));
      drain();
      send_good(8'h1C);
      drain();
      chk_state("after_timeout");

      // reset in the middle of a frame
      ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
      @(negedge CLK) RST = 1'b1;
      @(negedge CLK);
      chk("midrst_keys", keys, 64'd0);
      chk("midrst_outs", 64'({count, key_valid, key_code, key_ext, frame_err}), 64'd0);
      ps2data = 1'b1;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      model_reset();
      repeat (4) @(negedge CLK);
      send_good(8'h1C);
      drain();
      chk_state("after_midrst");

      // randomized traffic
      for (int n = 0; n < 80; n++) begin
         int sel;
         int er;
         logic [7:0] c;
         sel = $urandom_range(0, 9);
         er  = $urandom_range(0, 11);
         case (sel)
            0:       c = 8'hE0;
            1:       c = 8'hF0;
            2:       c = 8'h66;
            default: c = 8'($urandom_range(0, 255));
         endcase
         send_frame(c, er == 0, er == 1);
      end
      drain();
      chk_state("random_end");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
